// File: rtl/corr_pkg.sv
// Shared types and helpers for the correlator packet FIFO.
package corr_pkg;

  // Default packet layout and buffer sizing.
  localparam int PKT_BYTES_DEF = 4;
  localparam int DEPTH_DEF     = 10;
  localparam int DROPCNT_W_DEF = 8;

  // Serializer states: waiting for a packet, or pushing its bytes.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Free byte slots left in a FIFO of the given depth.
  function automatic int freeSpace(input int depth, input int nEntries);
    return depth - nEntries;
  endfunction

endpackage

// File: rtl/corr_bytefifo.sv
// Byte-wide circular FIFO with push, pop and flush. The depth need not be a
// power of two, so pointers wrap explicitly at DEPTH-1.
module corr_bytefifo #(
  parameter int DEPTH = 10,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cg,
  input  logic             i_push,
  input  logic [7:0]       i_pushData,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [7:0]       o_data,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_nEntries
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic [CNT_W-1:0] nEntries;
  logic             empty;
  logic             doPop;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
  endfunction

  assign empty = (nEntries == '0);
  // A pop against an empty FIFO is ignored rather than underflowing.
  assign doPop = i_pop && !empty;

  // Pointer and occupancy bookkeeping; flush beats push and pop.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rdPtr    <= '0;
      wrPtr    <= '0;
      nEntries <= '0;
    end else if (i_cg) begin
      if (i_flush) begin
        rdPtr    <= '0;
        wrPtr    <= '0;
        nEntries <= '0;
      end else begin
        if (i_push) wrPtr <= nextPtr(wrPtr);
        if (doPop)  rdPtr <= nextPtr(rdPtr);
        unique case ({i_push, doPop})
          2'b10:   nEntries <= nEntries + CNT_W'(1);
          2'b01:   nEntries <= nEntries - CNT_W'(1);
          default: nEntries <= nEntries;
        endcase
      end
    end
  end

  // Byte storage write port.
  // NOTE: storage has no reset; the reset pointers make stale contents unreachable.
  always_ff @(posedge i_clk) begin
    if (i_cg && i_push && !i_flush) mem[wrPtr] <= i_pushData;
  end

  assign o_data     = empty ? 8'h00 : mem[rdPtr];
  assign o_empty    = empty;
  assign o_nEntries = nEntries;

endmodule

// File: rtl/corr_pktfifo.sv
// Per-pair packet buffer: captures one correlator packet per window,
// serializes it MSB-first into a byte FIFO, and drops packets that do not
// fit whole, counting them in a saturating counter.
module corr_pktfifo
  import corr_pkg::*;
#(
  parameter int PKT_BYTES = PKT_BYTES_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int DROPCNT_W = DROPCNT_W_DEF
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_cg,
  input  logic [PKT_BYTES*8-1:0]        i_pkt_data,
  input  logic                          i_pkt_valid,
  output logic                          o_pkt_ready,
  output logic [7:0]                    o_data,
  output logic                          o_empty,
  input  logic                          i_pop,
  input  logic                          i_flush,
  output logic [$clog2(DEPTH+1)-1:0]    o_nEntries,
  output logic [DROPCNT_W-1:0]          o_dropCount
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_BYTES - 1);

  state_t                 stateQ, stateD;
  logic [IDX_W-1:0]       idxQ, idxD;
  logic [PKT_BYTES*8-1:0] stageQ, stageD;
  logic [DROPCNT_W-1:0]   dropCountQ, dropCountD;
  logic                   push;
  logic                   drop;
  logic [CNT_W-1:0]       nEntries;

  // Next-state, serializer and drop decisions.
  // NOTE: defaults first so no path leaves a variable unassigned (no latch).
  always_comb begin
    stateD     = stateQ;
    idxD       = idxQ;
    stageD     = stageQ;
    dropCountD = dropCountQ;
    push       = 1'b0;
    drop       = 1'b0;
    if (i_flush) begin
      // Abort serialization; a packet offered now is discarded uncounted.
      stateD     = IDLE;
      idxD       = '0;
      dropCountD = '0;
    end else begin
      unique case (stateQ)
        IDLE: begin
          if (i_pkt_valid) begin
            // Only registered occupancy is trusted; a same-cycle pop is not credited.
            if (freeSpace(DEPTH, int'(nEntries)) >= PKT_BYTES) begin
              stageD = i_pkt_data;
              idxD   = '0;
              stateD = SHIFT;
            end else begin
              drop = 1'b1;
            end
          end
        end
        SHIFT: begin
          // Space was reserved at capture, so this push cannot overflow.
          push   = 1'b1;
          stageD = stageQ << 8;
          if (idxQ == LAST_IDX) begin
            stateD = IDLE;
            idxD   = '0;
          end else begin
            idxD = idxQ + 1'b1;
          end
          if (i_pkt_valid) drop = 1'b1;
        end
        default: stateD = IDLE;
      endcase
      if (drop && (dropCountQ != '1)) dropCountD = dropCountQ + 1'b1;
    end
  end

  // Control state register, held while the clock gate is closed.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stateQ     <= IDLE;
      idxQ       <= '0;
      dropCountQ <= '0;
    end else if (i_cg) begin
      stateQ     <= stateD;
      idxQ       <= idxD;
      dropCountQ <= dropCountD;
    end
  end

  // Staging shift register; its top byte is always the next byte to push.
  always_ff @(posedge i_clk) begin
    if (i_cg) stageQ <= stageD;
  end

  corr_bytefifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_bytefifo (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_cg       (i_cg),
    .i_push     (push),
    .i_pushData (stageQ[PKT_BYTES*8-1 -: 8]),
    .i_pop      (i_pop),
    .i_flush    (i_flush),
    .o_data     (o_data),
    .o_empty    (o_empty),
    .o_nEntries (nEntries)
  );

  assign o_nEntries  = nEntries;
  assign o_dropCount = dropCountQ;
  assign o_pkt_ready = (stateQ == IDLE);

endmodule

// File: tb/tb_corr_pktfifo.sv
// Self-checking bench for corr_pktfifo (PKT_BYTES=4, DEPTH=10, DROPCNT_W=8).
module tb_corr_pktfifo;

  localparam int PKT_BYTES = 4;
  localparam int DEPTH     = 10;
  localparam int DROPCNT_W = 8;

  logic        clk;
  logic        rst;
  logic        cg;
  logic [31:0] pktData;
  logic        pktValid;
  logic        pktReady;
  logic [7:0]  data;
  logic        empty;
  logic        pop;
  logic        flush;
  logic [3:0]  nEntries;
  logic [7:0]  dropCount;

  int nChecks = 0;
  int nFails  = 0;
  logic [7:0] sb[$];
  int popped;

  typedef struct {
    logic        valid;
    logic [31:0] pkt;
    logic        pop;
    logic        empty;
    logic [7:0]  data;
    logic [3:0]  n;
    logic [7:0]  drop;
    logic        ready;
  } vec_t;

  vec_t vecs[10];

  corr_pktfifo #(
    .PKT_BYTES (PKT_BYTES),
    .DEPTH     (DEPTH),
    .DROPCNT_W (DROPCNT_W)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_cg        (cg),
    .i_pkt_data  (pktData),
    .i_pkt_valid (pktValid),
    .o_pkt_ready (pktReady),
    .o_data      (data),
    .o_empty     (empty),
    .i_pop       (pop),
    .i_flush     (flush),
    .o_nEntries  (nEntries),
    .o_dropCount (dropCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expectPkt(input logic [31:0] p);
    for (int b = 0; b < PKT_BYTES; b++) sb.push_back(p[31 - 8*b -: 8]);
  endtask

  // Strobe a packet expected to be accepted, then let it serialize.
  task automatic sendPkt(input logic [31:0] p);
    pktData  = p;
    pktValid = 1'b1;
    expectPkt(p);
    tick();
    pktValid = 1'b0;
    repeat (PKT_BYTES) tick();
  endtask

  // Strobe a packet expected to be dropped.
  task automatic dropPkt(input logic [31:0] p);
    pktData  = p;
    pktValid = 1'b1;
    tick();
    pktValid = 1'b0;
  endtask

  task automatic popCheck(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      if (sb.size() == 0) check({name, " sb_underflow"}, 32'(data), 32'hFFFF);
      else check(name, 32'(data), 32'(sb.pop_front()));
      pop = 1'b1;
      tick();
      pop = 1'b0;
    end
  endtask

  task automatic doFlush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cg = 1'b1; pktData = '0; pktValid = 1'b0; pop = 1'b0; flush = 1'b0;
    popped = 0;

    //           valid pkt           pop  empty data   n  drop   ready
    vecs[0] = '{1'b1, 32'hA1B2C3D4, 1'b0, 1'b1, 8'h00, 4'd0, 8'd0, 1'b0};
    vecs[1] = '{1'b0, 32'h0,        1'b0, 1'b0, 8'hA1, 4'd1, 8'd0, 1'b0};
    vecs[2] = '{1'b0, 32'h0,        1'b0, 1'b0, 8'hA1, 4'd2, 8'd0, 1'b0};
    vecs[3] = '{1'b0, 32'h0,        1'b0, 1'b0, 8'hA1, 4'd3, 8'd0, 1'b0};
    vecs[4] = '{1'b0, 32'h0,        1'b0, 1'b0, 8'hA1, 4'd4, 8'd0, 1'b1};
    vecs[5] = '{1'b0, 32'h0,        1'b1, 1'b0, 8'hB2, 4'd3, 8'd0, 1'b1};
    vecs[6] = '{1'b0, 32'h0,        1'b1, 1'b0, 8'hC3, 4'd2, 8'd0, 1'b1};
    vecs[7] = '{1'b0, 32'h0,        1'b1, 1'b0, 8'hD4, 4'd1, 8'd0, 1'b1};
    vecs[8] = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h00, 4'd0, 8'd0, 1'b1};
    vecs[9] = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h00, 4'd0, 8'd0, 1'b1};

    repeat (2) tick();
    rst = 1'b0;

    // Reset state
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_data", 32'(data), 32'h00);
    check("rst_n", 32'(nEntries), 32'd0);
    check("rst_drop", 32'(dropCount), 32'd0);
    check("rst_ready", 32'(pktReady), 32'd1);

    // 1. Basic path, table-driven cycle by cycle
    for (int i = 0; i < 10; i++) begin
      pktValid = vecs[i].valid;
      pktData  = vecs[i].pkt;
      pop      = vecs[i].pop;
      tick();
      check($sformatf("v%0d_empty", i), 32'(empty), 32'(vecs[i].empty));
      check($sformatf("v%0d_data", i), 32'(data), 32'(vecs[i].data));
      check($sformatf("v%0d_n", i), 32'(nEntries), 32'(vecs[i].n));
      check($sformatf("v%0d_drop", i), 32'(dropCount), 32'(vecs[i].drop));
      check($sformatf("v%0d_ready", i), 32'(pktReady), 32'(vecs[i].ready));
    end
    pktValid = 1'b0;
    pop = 1'b0;

    // 2. Full-FIFO drop
    sendPkt(32'h11121314);
    sendPkt(32'h21222324);
    check("full_n8", 32'(nEntries), 32'd8);
    dropPkt(32'h31323334);
    check("full_drop1", 32'(dropCount), 32'd1);
    check("full_n8_after_drop", 32'(nEntries), 32'd8);
    check("full_ready", 32'(pktReady), 32'd1);
    popCheck(2, "full_pop");
    check("full_n6", 32'(nEntries), 32'd6);
    sendPkt(32'h41424344);
    check("full_n10", 32'(nEntries), 32'd10);
    dropPkt(32'h51525354);
    check("full_drop2", 32'(dropCount), 32'd2);
    check("full_n10_after_drop", 32'(nEntries), 32'd10);
    popCheck(10, "full_drain");
    check("full_empty", 32'(empty), 32'd1);

    // 3. Drops while serializing
    doFlush();
    check("shdrop_flush_cnt", 32'(dropCount), 32'd0);
    pktData = 32'h61626364;
    pktValid = 1'b1;
    expectPkt(32'h61626364);
    tick();
    pktData = 32'h71727374;
    repeat (4) tick();
    pktValid = 1'b0;
    check("shdrop_cnt4", 32'(dropCount), 32'd4);
    check("shdrop_n4", 32'(nEntries), 32'd4);
    check("shdrop_ready", 32'(pktReady), 32'd1);
    popCheck(4, "shdrop_bytes");

    // 4. Flush mid-serialization; a packet in the flush cycle is discarded uncounted
    pktData = 32'h81828384;
    pktValid = 1'b1;
    tick();
    pktValid = 1'b0;
    tick();
    check("flush_pre_n1", 32'(nEntries), 32'd1);
    flush = 1'b1;
    pktValid = 1'b1;
    pktData = 32'h91929394;
    tick();
    flush = 1'b0;
    pktValid = 1'b0;
    check("flush_empty", 32'(empty), 32'd1);
    check("flush_n0", 32'(nEntries), 32'd0);
    check("flush_drop0", 32'(dropCount), 32'd0);
    check("flush_ready", 32'(pktReady), 32'd1);
    repeat (4) tick();
    check("flush_stay_empty", 32'(empty), 32'd1);
    check("flush_stay_n0", 32'(nEntries), 32'd0);
    sendPkt(32'hC1C2C3C4);
    popCheck(4, "flush_next_pkt");

    // 5. Pointer wrap: stream packets while popping whenever data is visible
    for (int p = 0; p < 6; p++) begin
      pktData = {8'(8'hE0 + p), 8'(8'hE1 + p), 8'(8'hF0 + p), 8'(8'hF1 + p)};
      pktValid = 1'b1;
      expectPkt(pktData);
      for (int c = 0; c < PKT_BYTES + 1; c++) begin
        pop = !empty;
        if (!empty) begin
          popped++;
          if (sb.size() == 0) check("wrap_sb_underflow", 32'(data), 32'hFFFF);
          else check("wrap_byte", 32'(data), 32'(sb.pop_front()));
        end
        tick();
        pktValid = 1'b0;
      end
    end
    for (int c = 0; c < 3; c++) begin
      pop = !empty;
      if (!empty) begin
        popped++;
        if (sb.size() == 0) check("wrap_sb_underflow", 32'(data), 32'hFFFF);
        else check("wrap_byte", 32'(data), 32'(sb.pop_front()));
      end
      tick();
    end
    pop = 1'b0;
    check("wrap_popped", 32'(popped), 32'd24);
    check("wrap_sb_left", 32'(sb.size()), 32'd0);
    check("wrap_empty", 32'(empty), 32'd1);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    check("pop_empty_n", 32'(nEntries), 32'd0);
    check("pop_empty_flag", 32'(empty), 32'd1);
    // Push and pop together at three entries
    pktData = 32'hA5B6C7D8;
    pktValid = 1'b1;
    expectPkt(32'hA5B6C7D8);
    tick();
    pktValid = 1'b0;
    repeat (3) tick();
    check("pp_pre_n3", 32'(nEntries), 32'd3);
    check("pp_head", 32'(data), 32'(sb.pop_front()));
    pop = 1'b1;
    tick();
    pop = 1'b0;
    check("pp_n3", 32'(nEntries), 32'd3);
    popCheck(3, "pp_bytes");

    // 6. Clock gate holds everything, then the counter saturates
    doFlush();
    sendPkt(32'h01020304);
    sendPkt(32'h05060708);
    check("cg_pre_n8", 32'(nEntries), 32'd8);
    cg = 1'b0;
    pktValid = 1'b1;
    pktData = 32'hDEADBEEF;
    pop = 1'b1;
    repeat (3) tick();
    pop = 1'b0;
    check("cg_n8", 32'(nEntries), 32'd8);
    check("cg_drop0", 32'(dropCount), 32'd0);
    check("cg_head", 32'(data), 32'(sb[0]));
    check("cg_ready", 32'(pktReady), 32'd1);
    cg = 1'b1;
    repeat (300) tick();
    pktValid = 1'b0;
    check("sat_drop255", 32'(dropCount), 32'd255);
    check("sat_n8", 32'(nEntries), 32'd8);
    popCheck(8, "sat_bytes");
    doFlush();
    check("final_drop0", 32'(dropCount), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end

endmodule
